// File: rtl/sparrow_lpmul.sv
`default_nettype none
// sparrow_lpmul: 8x8 -> 16 low-precision multiplier with signed/unsigned and saturate modes.
// Rev 1.0: initial release.

package sparrow;
  typedef logic [7:0]  vector_component;
  typedef logic [15:0] high_prec_component;

  typedef struct packed {
    vector_component opA;
    vector_component opB;
    logic            sign;
    logic            sat;
  } lpmul_in_type;

  typedef struct packed {
    high_prec_component mul_res;
  } lpmul_out_type;
endpackage

module sparrow_lpmul
  import sparrow::*;
(
  input  logic          clk,
  input  logic          rst,
  input  lpmul_in_type  muli,
  input  logic          in_valid,
  output lpmul_out_type mulo,
  output logic          out_valid
);

  localparam logic signed [17:0] S_MAX = 18'sd127;
  localparam logic signed [17:0] S_MIN = -18'sd128;
  localparam logic signed [17:0] U_MAX = 18'sd255;

  logic signed [8:0]  ext_a;
  logic signed [8:0]  ext_b;
  logic signed [17:0] prod;
  high_prec_component res;
  high_prec_component res_d, res_q;
  logic               valid_d, valid_q;

  always_comb begin
    ext_a = muli.sign ? {muli.opA[7], muli.opA} : {1'b0, muli.opA};
    ext_b = muli.sign ? {muli.opB[7], muli.opB} : {1'b0, muli.opB};
    prod  = ext_a * ext_b;

    res = prod[15:0];
    // Unsigned products are never negative, so only the upper bound matters there.
    if (muli.sat) begin
      if (muli.sign) begin
        if (prod > S_MAX)      res = 16'h007F;
        else if (prod < S_MIN) res = 16'hFF80;
      end else if (prod > U_MAX) begin
        res = 16'h00FF;
      end
    end

    res_d   = in_valid ? res : res_q;
    valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign mulo.mul_res = res_q;
  assign out_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sparrow_lpmul.sv
`default_nettype none
// tb_sparrow_lpmul: directed self-checking bench for sparrow_lpmul.
// Rev 1.0: initial release.

module tb_sparrow_lpmul;
  import sparrow::*;

  logic          clk = 1'b0;
  logic          rst;
  lpmul_in_type  muli;
  logic          in_valid;
  lpmul_out_type mulo;
  logic          out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  sparrow_lpmul dut (
    .clk       (clk),
    .rst       (rst),
    .muli      (muli),
    .in_valid  (in_valid),
    .mulo      (mulo),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sign;
    logic        sat;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h007F},
    '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hFF80},
    '{8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01},
    '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000},
    '{8'hFF, 8'h02, 1'b1, 1'b0, 16'hFFFE},
    '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01},
    '{8'hFF, 8'hFF, 1'b0, 1'b1, 16'h00FF},
    '{8'h04, 8'h10, 1'b0, 1'b1, 16'h0040},
    '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h0080},
    '{8'h80, 8'hFF, 1'b1, 1'b1, 16'h007F},
    '{8'hFE, 8'h40, 1'b1, 1'b1, 16'hFF80},
    '{8'hFE, 8'h41, 1'b1, 1'b1, 16'hFF80},
    '{8'h7F, 8'h01, 1'b1, 1'b1, 16'h007F},
    '{8'h40, 8'h02, 1'b1, 1'b1, 16'h007F},
    '{8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1},
    '{8'h80, 8'h02, 1'b0, 1'b0, 16'h0100},
    '{8'h80, 8'h02, 1'b0, 1'b1, 16'h00FF},
    '{8'hFF, 8'h01, 1'b0, 1'b1, 16'h00FF},
    '{8'h10, 8'h07, 1'b1, 1'b1, 16'h0070}
  };

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic t);
    in_valid  = v;
    muli.opA  = a;
    muli.opB  = b;
    muli.sign = s;
    muli.sat  = t;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 8'h7F, 8'h7F, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", mulo.mul_res, 16'h0000);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);

    // First op after reset: not visible before the edge, visible right after.
    rst = 1'b0;
    drive(1'b1, 8'h7F, 8'h7F, 1'b1, 1'b1);
    #3;
    check("post_rst_pre_edge_valid", {15'b0, out_valid}, 16'h0000);
    @(posedge clk); #1;
    check("post_rst_res", mulo.mul_res, 16'h007F);
    check("post_rst_valid", {15'b0, out_valid}, 16'h0001);

    // Back-to-back stream through the whole table.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sign, vecs[i].sat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_res", i), mulo.mul_res, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {15'b0, out_valid}, 16'h0001);
    end

    // Idle: operands change but must be ignored, result holds.
    drive(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("idle_valid", {15'b0, out_valid}, 16'h0000);
    check("idle_res", mulo.mul_res, 16'h0070);
    @(posedge clk); #1;
    check("idle2_res", mulo.mul_res, 16'h0070);

    // Reset drops a concurrent valid op.
    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst2_res", mulo.mul_res, 16'h0000);
    check("rst2_valid", {15'b0, out_valid}, 16'h0000);
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst2_after_res", mulo.mul_res, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparrow_lpmul.md
# sparrow_lpmul

Low-precision multiplier `lpmul` for the Sparrow vector datapath.
- Multiplies two 8-bit `vector_component` operands into a 16-bit `high_prec_component` result.
- Per-operation flags select signed or unsigned interpretation, and saturation to the 8-bit element range or the full-precision product.
- Sits in each vector lane between the operand registers and the accumulator/writeback stage; uses the `sparrow` package types.

## Interface

Parameters: none; widths are fixed by `sparrow` package types (`vector_component` = 8 bits, `high_prec_component` = 16 bits).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `muli`  in  `lpmul_in_type`  packed struct with these fields:
  - `opA` [7:0] operand A.
  - `opB` [7:0] operand B.
  - `sign` 1 = two's-complement operands; 0 = unsigned.
  - `sat` 1 = saturate to 8-bit element range; 0 = full 16-bit product.
- `in_valid`  in  1  `muli` holds a valid operation this cycle.
- `mulo`  out  `lpmul_out_type`  packed struct; field `mul_res` [15:0] is the result.
- `out_valid`  out  1  `mulo.mul_res` holds a valid result this cycle.

## Operation

- Operand extension to 9 bits:
  - `sign`=1: sign-extend `opA` and `opB`.
  - `sign`=0: zero-extend both.
- Full product P = extA × extB, computed exactly (18-bit intermediate).
  - Signed range is [-16256, 16384].
  - Unsigned range is [0, 65025].
- `sat`=0:
  - `mul_res` = P[15:0].
  - Exact in both modes: signed P fits in int16, unsigned P fits in uint16.
- `sat`=1, `sign`=1:
  - P clamped to [-128, 127].
  - `mul_res` = clamped value sign-extended to 16 bits.
- `sat`=1, `sign`=0:
  - P clamped to [0, 255].
  - `mul_res` = clamped value zero-extended to 16 bits.
- Saturation applies only when P is outside the range; in-range values pass unchanged.
- `sign` and `sat` are sampled per operation together with the operands. There is no persistent mode state.
- `in_valid`=0:
  - Operands ignored.
  - `mulo.mul_res` holds its previous value.
  - `out_valid` deasserts next cycle.

## Timing

- Single-stage pipeline; latency is 1 cycle.
  - Inputs sampled on edge N with `in_valid`=1.
  - `mul_res` and `out_valid`=1 are presented after edge N.
  - They hold until edge N+1.
- Throughput: one operation per cycle, no stalls, no backpressure.
- Back-to-back valid inputs produce back-to-back valid outputs in order.
- Reset (`rst`=1 at an edge):
  - `mul_res` = 16'h0000, `out_valid` = 0.
  - Reset overrides any concurrent `in_valid`.
  - An operation sampled on the same edge as reset is dropped.
  - The first valid input accepted after reset deassertion appears one cycle later.
- Outputs are purely registered: no combinational path from `muli`/`in_valid` to `mulo`/`out_valid`.

## Test plan

- Reset: assert `rst` with `in_valid`=1, opA=opB=8'h7F → `mul_res`=16'h0000, `out_valid`=0. On the first post-reset valid op, the result appears one cycle later.
- Signed saturate:
  - opA=opB=8'h7F, sign=1, sat=1 → `mul_res`=16'h007F (127).
  - opA=8'h80, opB=8'h7F, sign=1, sat=1 → 16'hFF80 (-128).
- Signed full precision:
  - opA=opB=8'h7F, sign=1, sat=0 → 16'h3F01 (16129).
  - opA=opB=8'h80, sign=1, sat=0 → 16'h4000 (16384).
  - opA=8'hFF, opB=8'h02, sign=1, sat=0 → 16'hFFFE (-2).
- Unsigned:
  - opA=opB=8'hFF, sign=0, sat=0 → 16'hFE01 (65025).
  - Same operands with sat=1 → 16'h00FF.
  - opA=8'h04, opB=8'h10, sign=0, sat=1 → 16'h0040 (in range, unchanged).
- Streaming: three consecutive valid ops with mixed sign/sat → three consecutive correct results, 1-cycle latency, each using its own flags.
- Idle hold: a valid op followed by `in_valid`=0 → `out_valid` drops and `mul_res` keeps the last result.
